// File: rtl/phy_pkg.sv
// Constants and lane-state encoding shared by the transmit serializer and
// the receive-side deserializer.
package phy_pkg;

    localparam int          WORD_W   = 8;
    localparam logic [7:0]  COM_CHAR = 8'hBC;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } lane_state_t;

endpackage

// File: rtl/par_serial_tx.sv
// Parallel-to-serial transmit stage: one {valid, byte} word every WORD_W bit
// clocks, sent MSB-first, with comma fill for idle words and post-reset sync.
module par_serial_tx
    import phy_pkg::lane_state_t;
    import phy_pkg::SYNC;
    import phy_pkg::ACTIVE;
#(
    parameter int                 WORD_W     = phy_pkg::WORD_W,
    parameter logic [WORD_W-1:0]  COM_CHAR   = phy_pkg::COM_CHAR,
    parameter int                 SYNC_WORDS = 4
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic [WORD_W:0]   data_in,
    output logic              load_req,
    output logic              data_out,
    output logic              active
);

    localparam int             CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [7:0]     SYNC_LAST = 8'(SYNC_WORDS - 1);

    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WORD_W-1:0]  sh_reg, sh_next;
    logic [7:0]         scnt_reg, scnt_next;
    lane_state_t        state_reg, state_next;

    // cnt resets to its last value so the first edge after release loads a word.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            cnt_reg   <= CNT_LAST;
            sh_reg    <= '0;
            scnt_reg  <= '0;
            state_reg <= SYNC;
        end else begin
            cnt_reg   <= cnt_next;
            sh_reg    <= sh_next;
            scnt_reg  <= scnt_next;
            state_reg <= state_next;
        end
    end

    always_comb begin
        cnt_next   = cnt_reg + 1'b1;
        sh_next    = {sh_reg[WORD_W-2:0], 1'b0};
        scnt_next  = scnt_reg;
        state_next = state_reg;
        if (load_req) begin
            cnt_next = '0;
            case (state_reg)
                SYNC: begin
                    sh_next   = COM_CHAR;
                    scnt_next = scnt_reg + 8'd1;
                    if (scnt_reg == SYNC_LAST) begin
                        state_next = ACTIVE;
                    end
                end
                ACTIVE: begin
                    sh_next = data_in[WORD_W] ? data_in[WORD_W-1:0] : COM_CHAR;
                end
                default: begin
                    state_next = SYNC;
                end
            endcase
        end
    end

    assign load_req = (cnt_reg == CNT_LAST);
    assign data_out = sh_reg[WORD_W-1];
    assign active   = (state_reg == ACTIVE);

endmodule

// File: tb/tb_par_serial_tx.sv
// Directed bench for par_serial_tx: sync sequence, data/idle selection,
// load timing, mid-word reset and the single-sync-word configuration.
module tb_par_serial_tx;

    logic       clk = 1'b0;
    logic       reset4;
    logic       reset1;
    logic [8:0] data_in;
    logic       lq4, do4, act4;
    logic       lq1, do1, act1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    par_serial_tx #(.SYNC_WORDS(4)) dut4 (
        .clk_32f  (clk),
        .reset    (reset4),
        .data_in  (data_in),
        .load_req (lq4),
        .data_out (do4),
        .active   (act4)
    );

    par_serial_tx #(.SYNC_WORDS(1)) dut1 (
        .clk_32f  (clk),
        .reset    (reset1),
        .data_in  (data_in),
        .load_req (lq1),
        .data_out (do1),
        .active   (act1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge inside a load_req cycle; collects the 8 bits that follow.
    task automatic recv_word(input bit sel, input bit toggle, input logic [8:0] final_val,
                             output logic [7:0] w, output logic act_first, output int lq_cnt);
        w = '0;
        act_first = 1'b0;
        lq_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            w = {w[6:0], (sel ? do1 : do4)};
            if (i == 0) act_first = sel ? act1 : act4;
            if (sel ? lq1 : lq4) lq_cnt++;
            if (toggle) data_in = (i == 7) ? final_val : 9'($urandom);
        end
    endtask

    task automatic expect_word(input string tag, input bit sel, input bit toggle,
                               input logic [8:0] final_val, input logic [7:0] exp_w,
                               input logic exp_act);
        logic [7:0] w;
        logic       act_first;
        int         lq_cnt;
        chk({tag, "_lq_start"}, 32'(sel ? lq1 : lq4), 32'd1);
        recv_word(sel, toggle, final_val, w, act_first, lq_cnt);
        $display("word %s: sent %02h active=%0b load_req_pulses=%0d", tag, w, act_first, lq_cnt);
        chk({tag, "_bits"}, 32'(w), 32'(exp_w));
        chk({tag, "_active"}, 32'(act_first), 32'(exp_act));
        chk({tag, "_lq_pulses"}, 32'(lq_cnt), 32'd1);
    endtask

    initial begin
        reset4  = 1'b0;
        reset1  = 1'b0;
        data_in = 9'h1A5;
        repeat (3) @(negedge clk);
        chk("rst_data_out", 32'(do4), 32'd0);
        chk("rst_active", 32'(act4), 32'd0);
        chk("rst_load_req", 32'(lq4), 32'd1);

        // 1: four sync commas, active rises on the edge loading the 4th
        reset4 = 1'b1;
        expect_word("t1_sync0", 1'b0, 1'b0, 9'h0, 8'hBC, 1'b0);
        expect_word("t1_sync1", 1'b0, 1'b0, 9'h0, 8'hBC, 1'b0);
        expect_word("t1_sync2", 1'b0, 1'b0, 9'h0, 8'hBC, 1'b0);
        expect_word("t1_sync3", 1'b0, 1'b0, 9'h0, 8'hBC, 1'b1);
        expect_word("t1_data",  1'b0, 1'b0, 9'h0, 8'hA5, 1'b1);

        // 2: invalid word becomes comma, valid 3C passes
        data_in = 9'h0FF;
        expect_word("t2_idle", 1'b0, 1'b0, 9'h0, 8'hBC, 1'b1);
        data_in = 9'h13C;
        expect_word("t2_data", 1'b0, 1'b0, 9'h0, 8'h3C, 1'b1);

        // 3: alternating all-zero / all-one data
        data_in = 9'h100;
        expect_word("t3_w0", 1'b0, 1'b0, 9'h0, 8'h00, 1'b1);
        data_in = 9'h1FF;
        expect_word("t3_w1", 1'b0, 1'b0, 9'h0, 8'hFF, 1'b1);
        data_in = 9'h100;
        expect_word("t3_w2", 1'b0, 1'b0, 9'h0, 8'h00, 1'b1);
        data_in = 9'h1FF;
        expect_word("t3_w3", 1'b0, 1'b0, 9'h0, 8'hFF, 1'b1);

        // 4: data_in churns between load edges; only the held 155 is sent
        data_in = 9'h1FF;
        expect_word("t4_churn", 1'b0, 1'b1, 9'h155, 8'hFF, 1'b1);
        expect_word("t4_held",  1'b0, 1'b0, 9'h0,   8'h55, 1'b1);

        // 5: reset in the middle of a data word
        data_in = 9'h1FF;
        chk("t5_lq_start", 32'(lq4), 32'd1);
        repeat (3) tick;
        chk("t5_pre_bit", 32'(do4), 32'd1);
        #1 reset4 = 1'b0;
        #1;
        chk("t5_rst_data_out", 32'(do4), 32'd0);
        chk("t5_rst_active", 32'(act4), 32'd0);
        chk("t5_rst_load_req", 32'(lq4), 32'd1);
        repeat (2) @(negedge clk);
        reset4 = 1'b1;
        expect_word("t5_sync0", 1'b0, 1'b0, 9'h0, 8'hBC, 1'b0);
        expect_word("t5_sync1", 1'b0, 1'b0, 9'h0, 8'hBC, 1'b0);
        expect_word("t5_sync2", 1'b0, 1'b0, 9'h0, 8'hBC, 1'b0);
        expect_word("t5_sync3", 1'b0, 1'b0, 9'h0, 8'hBC, 1'b1);
        expect_word("t5_data",  1'b0, 1'b0, 9'h0, 8'hFF, 1'b1);

        // 6: single sync word, then a valid byte equal to the comma
        chk("t6_rst_active", 32'(act1), 32'd0);
        chk("t6_rst_data_out", 32'(do1), 32'd0);
        data_in = 9'h1BC;
        reset1  = 1'b1;
        expect_word("t6_sync", 1'b1, 1'b0, 9'h0, 8'hBC, 1'b1);
        expect_word("t6_data", 1'b1, 1'b0, 9'h0, 8'hBC, 1'b1);
        data_in = 9'h1A5;
        expect_word("t6_next", 1'b1, 1'b0, 9'h0, 8'hA5, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
